// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared playfield geometry, ball-controller state encoding
//                and direction encoding for the pong game logic.
//  Contents    : c_* geometry constants, state_e, dir_e, dir_flip()
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Playfield and object geometry (pixels)
    localparam int c_h_res       = 640;
    localparam int c_v_res       = 480;
    localparam int c_ball        = 8;
    localparam int c_step        = 2;
    localparam int c_paddle_w    = 8;
    localparam int c_paddle_h    = 64;
    localparam int c_pl_x        = 16;
    localparam int c_pr_x        = 616;
    localparam int c_point_ticks = 60;
    localparam int c_win_score   = 9;

    // Game-flow states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Axis direction: POS = right (x) or down (y)
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    function automatic dir_e dir_flip(input dir_e d);
        return (d == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ball_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ball_controller
//  Description : Pong game logic. Moves the ball once per tick, bounces it
//                off the top/bottom walls and both paddles, detects goals,
//                keeps score and sequences IDLE/PLAY/POINT/OVER.
//  Ports       : clk, rst (async, active-high)
//                tick      - frame-rate movement strobe
//                start     - serve / new-game request (level)
//                pl_y/pr_y - left/right paddle top edge
//                ball_x/y  - ball top-left corner
//                hit/wall/goal - one-cycle event strobes
//                score_l/r - player scores, game_over - high in OVER
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_controller
    import pong_pkg::*;
#(
    parameter int H_RES       = c_h_res,
    parameter int V_RES       = c_v_res,
    parameter int BALL        = c_ball,
    parameter int STEP        = c_step,
    parameter int PADDLE_W    = c_paddle_w,
    parameter int PADDLE_H    = c_paddle_h,
    parameter int PL_X        = c_pl_x,
    parameter int PR_X        = c_pr_x,
    parameter int POINT_TICKS = c_point_ticks,
    parameter int WIN_SCORE   = c_win_score
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] pl_y,
    input  logic [9:0] pr_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       wall,
    output logic       goal,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam int                 c_cnt_w    = $clog2(POINT_TICKS + 1);
    localparam logic [10:0]        c_stp      = 11'(STEP);
    localparam logic [10:0]        c_bw       = 11'(BALL);
    localparam logic [10:0]        c_x_max    = 11'(H_RES - BALL);
    localparam logic [10:0]        c_y_max    = 11'(V_RES - BALL);
    localparam logic [10:0]        c_pr_face  = 11'(PR_X);
    localparam logic [10:0]        c_pr_stop  = 11'(PR_X - BALL);
    localparam logic [10:0]        c_pl_face  = 11'(PL_X + PADDLE_W);
    localparam logic [10:0]        c_pad_h    = 11'(PADDLE_H);
    localparam logic [9:0]         c_x_ctr    = 10'((H_RES - BALL) / 2);
    localparam logic [9:0]         c_y_ctr    = 10'((V_RES - BALL) / 2);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(POINT_TICKS - 1);
    localparam logic [3:0]         c_win      = 4'(WIN_SCORE);

    state_e               state_q,   state_d;
    logic [9:0]           x_q,       x_d;
    logic [9:0]           y_q,       y_d;
    dir_e                 dx_q,      dx_d;
    dir_e                 dy_q,      dy_d;
    logic [3:0]           score_l_q, score_l_d;
    logic [3:0]           score_r_q, score_r_d;
    logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
    logic                 hit_q,     hit_d;
    logic                 wall_q,    wall_d;
    logic                 goal_q,    goal_d;

    // Candidate move and collision terms, all in 11 bits so that x+BALL and
    // paddle_top+PADDLE_H never wrap.
    logic [10:0] w_x, w_y, w_nx, w_ny, w_pl_top, w_pr_top;
    logic        w_wall, w_hit_r, w_hit_l, w_goal_l, w_goal_r;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= c_x_ctr;
            y_q       <= c_y_ctr;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            wall_q    <= 1'b0;
            goal_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            wall_q    <= wall_d;
            goal_q    <= goal_d;
        end
    end

    // ------------------------------------------------------------------------
    // Candidate position and collision detection
    // ------------------------------------------------------------------------
    always_comb begin
        w_x      = {1'b0, x_q};
        w_y      = {1'b0, y_q};
        w_pl_top = {1'b0, pl_y};
        w_pr_top = {1'b0, pr_y};
        w_wall   = 1'b0;

        // Moving toward 0 saturates instead of underflowing.
        if (dx_q == DIR_POS)    w_nx = w_x + c_stp;
        else if (w_x <= c_stp)  w_nx = '0;
        else                    w_nx = w_x - c_stp;

        if (dy_q == DIR_POS)    w_ny = w_y + c_stp;
        else if (w_y <= c_stp)  w_ny = '0;
        else                    w_ny = w_y - c_stp;

        if (w_ny == '0) begin
            w_wall = 1'b1;
        end else if (w_ny >= c_y_max) begin
            w_ny   = c_y_max;
            w_wall = 1'b1;
        end

        // A paddle bounce needs the ball to cross the paddle face this tick
        // while vertically overlapping the paddle at its new height.
        w_hit_r = (dx_q == DIR_POS)
               && (w_x + c_bw <= c_pr_face)
               && (w_nx + c_bw >= c_pr_face)
               && (w_ny + c_bw > w_pr_top)
               && (w_ny < w_pr_top + c_pad_h);

        w_hit_l = (dx_q == DIR_NEG)
               && (w_x >= c_pl_face)
               && (w_nx <= c_pl_face)
               && (w_ny + c_bw > w_pl_top)
               && (w_ny < w_pl_top + c_pad_h);

        w_goal_l = (w_nx >= c_x_max);
        w_goal_r = (w_nx == '0);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        cnt_d     = cnt_q;
        hit_d     = 1'b0;
        wall_d    = 1'b0;
        goal_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (tick) begin
                    x_d    = w_nx[9:0];
                    y_d    = w_ny[9:0];
                    wall_d = w_wall;
                    if (w_wall) dy_d = dir_flip(dy_q);

                    // Paddle bounce wins over goal.
                    if (w_hit_r) begin
                        x_d   = c_pr_stop[9:0];
                        dx_d  = DIR_NEG;
                        hit_d = 1'b1;
                    end else if (w_hit_l) begin
                        x_d   = c_pl_face[9:0];
                        dx_d  = DIR_POS;
                        hit_d = 1'b1;
                    end else if (w_goal_l) begin
                        x_d       = c_x_max[9:0];
                        goal_d    = 1'b1;
                        score_l_d = score_l_q + 4'd1;
                        cnt_d     = '0;
                        state_d   = ST_POINT;
                    end else if (w_goal_r) begin
                        x_d       = '0;
                        goal_d    = 1'b1;
                        score_r_d = score_r_q + 4'd1;
                        cnt_d     = '0;
                        state_d   = ST_POINT;
                    end
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (cnt_q == c_cnt_last) begin
                        // dx is left as-is: it still points at the side
                        // that conceded, which is who serves next.
                        cnt_d = '0;
                        x_d   = c_x_ctr;
                        y_d   = c_y_ctr;
                        dy_d  = DIR_POS;
                        if (score_l_q == c_win || score_r_q == c_win)
                            state_d = ST_OVER;
                        else
                            state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (start) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    x_d       = c_x_ctr;
                    y_d       = c_y_ctr;
                    dy_d      = DIR_POS;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        ball_x    = x_q;
        ball_y    = y_q;
        hit       = hit_q;
        wall      = wall_q;
        goal      = goal_q;
        score_l   = score_l_q;
        score_r   = score_r_q;
        game_over = (state_q == ST_OVER);
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_controller
//  Description : Self-checking bench for ball_controller. A behavioural game
//                model tracks position, direction, scores and mode using
//                plain integer arithmetic; directed scenarios and a random
//                run compare every output against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_controller;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int B   = 8;
    localparam int S   = 2;
    localparam int PW  = 8;
    localparam int PH  = 64;
    localparam int PLX = 16;
    localparam int PRX = 616;
    localparam int PT  = 60;
    localparam int WIN = 9;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_POINT = 2;
    localparam int M_OVER  = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pl_y  = 10'd900;
    logic [9:0] pr_y  = 10'd900;
    logic [9:0] ball_x, ball_y;
    logic       hit, wall, goal, game_over;
    logic [3:0] score_l, score_r;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_mode, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt;
    bit m_hit, m_wall, m_goal;

    ball_controller #(
        .H_RES(H), .V_RES(V), .BALL(B), .STEP(S), .PADDLE_W(PW),
        .PADDLE_H(PH), .PL_X(PLX), .PR_X(PRX), .POINT_TICKS(PT),
        .WIN_SCORE(WIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .pl_y     (pl_y),
        .pr_y     (pr_y),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .hit      (hit),
        .wall     (wall),
        .goal     (goal),
        .score_l  (score_l),
        .score_r  (score_r),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_vec();
        return {ball_x, ball_y, hit, wall, goal, score_l, score_r, game_over};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {10'(m_x), 10'(m_y), m_hit, m_wall, m_goal,
                4'(m_sl), 4'(m_sr), (m_mode == M_OVER)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_x = (H - B) / 2; m_y = (V - B) / 2;
        m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_cnt = 0;
        m_hit = 0; m_wall = 0; m_goal = 0;
    endtask

    task automatic recentre();
        m_x = (H - B) / 2; m_y = (V - B) / 2; m_dy = 1;
    endtask

    // One game step following the rules: move, wall, paddle, goal.
    task automatic model_step(input bit t, input bit s, input int ply, input int pry);
        int nx, ny;
        m_hit = 0; m_wall = 0; m_goal = 0;
        case (m_mode)
            M_IDLE: if (s) m_mode = M_PLAY;
            M_PLAY: if (t) begin
                nx = m_dx ? m_x + S : m_x - S;
                ny = m_dy ? m_y + S : m_y - S;
                if (nx < 0) nx = 0;
                if (ny < 0) ny = 0;
                if (ny <= 0)        begin ny = 0;     m_dy = 1; m_wall = 1; end
                else if (ny >= V-B) begin ny = V - B; m_dy = 0; m_wall = 1; end
                if (m_dx == 1 && m_x + B <= PRX && nx + B >= PRX &&
                    ny + B > pry && ny < pry + PH) begin
                    nx = PRX - B; m_dx = 0; m_hit = 1;
                end else if (m_dx == 0 && m_x >= PLX + PW && nx <= PLX + PW &&
                             ny + B > ply && ny < ply + PH) begin
                    nx = PLX + PW; m_dx = 1; m_hit = 1;
                end else if (nx >= H - B) begin
                    nx = H - B; m_goal = 1; m_sl++; m_mode = M_POINT; m_cnt = 0;
                end else if (nx <= 0) begin
                    nx = 0; m_goal = 1; m_sr++; m_mode = M_POINT; m_cnt = 0;
                end
                m_x = nx; m_y = ny;
            end
            M_POINT: if (t) begin
                m_cnt++;
                if (m_cnt == PT) begin
                    m_cnt = 0;
                    recentre();
                    m_mode = (m_sl == WIN || m_sr == WIN) ? M_OVER : M_IDLE;
                end
            end
            default: if (s) begin
                m_sl = 0; m_sr = 0; recentre(); m_mode = M_IDLE;
            end
        endcase
    endtask

    // Drive one clock cycle and advance the model on the same edge.
    task automatic step(input bit t, input bit s);
        tick = t; start = s;
        @(posedge clk);
        model_step(t, s, int'(pl_y), int'(pr_y));
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== {10'd316, 10'd236, 3'b000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", dut_vec(),
                     {10'd316, 10'd236, 3'b000, 8'h00, 1'b0});
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL idle_tick %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            errors++;
            $display("FAIL idle_parked: got (%0d,%0d) want (316,236)", ball_x, ball_y);
        end
    endtask

    task automatic test_wall();
        pl_y = 10'd900; pr_y = 10'd900;
        step(1'b0, 1'b1);
        for (int n = 1; n <= 119; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wall_run tick %0d: got %h want %h", n, dut_vec(), exp_vec());
            end
            if (n == 118) begin
                checks++;
                if (ball_y !== 10'd472 || wall !== 1'b1) begin
                    errors++;
                    $display("FAIL wall_bottom: got y=%0d wall=%b want y=472 wall=1", ball_y, wall);
                end
                step(1'b0, 1'b0);
                checks++;
                if (wall !== 1'b0 || ball_y !== 10'd472) begin
                    errors++;
                    $display("FAIL wall_one_cycle: got y=%0d wall=%b want y=472 wall=0", ball_y, wall);
                end
            end
            if (n == 119) begin
                checks++;
                if (ball_y !== 10'd470) begin
                    errors++;
                    $display("FAIL wall_reverse: got y=%0d want 470", ball_y);
                end
            end
        end
    endtask

    task automatic test_hit();
        pr_y = 10'd400;
        for (int n = 120; n <= 147; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hit_run tick %0d: got %h want %h", n, dut_vec(), exp_vec());
            end
            if (n == 146) begin
                checks++;
                if (ball_x !== 10'd608 || ball_y !== 10'd416 || hit !== 1'b1) begin
                    errors++;
                    $display("FAIL hit_right: got (%0d,%0d) hit=%b want (608,416) hit=1",
                             ball_x, ball_y, hit);
                end
            end
            if (n == 147) begin
                checks++;
                if (ball_x !== 10'd606 || hit !== 1'b0) begin
                    errors++;
                    $display("FAIL hit_rebound: got x=%0d hit=%b want x=606 hit=0", ball_x, hit);
                end
            end
        end
    endtask

    task automatic test_goal();
        do_reset();
        pr_y = 10'd0; pl_y = 10'd900;
        step(1'b0, 1'b1);
        for (int n = 1; n <= 158; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL goal_run tick %0d: got %h want %h", n, dut_vec(), exp_vec());
            end
            if (n == 146) begin
                checks++;
                if (hit !== 1'b0) begin
                    errors++;
                    $display("FAIL goal_no_hit: got hit=%b want 0", hit);
                end
            end
        end
        checks++;
        if (ball_x !== 10'd632 || goal !== 1'b1 || score_l !== 4'd1 || score_r !== 4'd0) begin
            errors++;
            $display("FAIL goal_right: got x=%0d goal=%b sl=%0d sr=%0d want x=632 goal=1 sl=1 sr=0",
                     ball_x, goal, score_l, score_r);
        end
        for (int k = 1; k <= PT; k++) begin
            step(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL point_hold tick %0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL point_recentre: got (%0d,%0d) over=%b want (316,236) over=0",
                     ball_x, ball_y, game_over);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            errors++;
            $display("FAIL serve_dir: got (%0d,%0d) want (318,238)", ball_x, ball_y);
        end
    endtask

    task automatic test_game_over();
        int budget;
        budget = 10000;
        while (m_mode != M_OVER && budget > 0) begin
            step(1'b1, m_mode == M_IDLE);
            budget--;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rally: got %h want %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL game_over_timeout: got no OVER want OVER within budget");
        end
        checks++;
        if (game_over !== 1'b1 || score_l !== 4'd9 || score_r !== 4'd0) begin
            errors++;
            $display("FAIL game_over_set: got over=%b sl=%0d sr=%0d want over=1 sl=9 sr=0",
                     game_over, score_l, score_r);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        checks++;
        if (game_over !== 1'b1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            errors++;
            $display("FAIL over_ignores_tick: got over=%b (%0d,%0d) want over=1 (316,236)",
                     game_over, ball_x, ball_y);
        end
        step(1'b0, 1'b1);
        checks++;
        if (game_over !== 1'b0 || score_l !== 4'd0 || score_r !== 4'd0) begin
            errors++;
            $display("FAIL new_game: got over=%b sl=%0d sr=%0d want over=0 sl=0 sr=0",
                     game_over, score_l, score_r);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) pl_y = 10'($urandom_range(0, 440));
            if ($urandom_range(0, 15) == 0) pr_y = 10'($urandom_range(0, 440));
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                model_reset();
                #1;
                rst = 1'b0;
            end else begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pl_y = 10'd900; pr_y = 10'd400;
        step(1'b0, 1'b1);
        for (int n = 1; n <= 145; n++) step(1'b1, 1'b0);
        checks++;
        if (ball_x !== 10'd606 || ball_y !== 10'd418) begin
            errors++;
            $display("FAIL pre_hit_pos: got (%0d,%0d) want (606,418)", ball_x, ball_y);
        end
        // Next tick would bounce off the right paddle; reset lands first.
        tick = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== {10'd316, 10'd236, 3'b000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", dut_vec(),
                     {10'd316, 10'd236, 3'b000, 8'h00, 1'b0});
        end
        @(posedge clk);
        #1;
        checks++;
        if (hit !== 1'b0 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            errors++;
            $display("FAIL reset_drops_hit: got hit=%b (%0d,%0d) want hit=0 (316,236)",
                     hit, ball_x, ball_y);
        end
        rst = 1'b0; tick = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wall();
        test_hit();
        test_goal();
        test_game_over();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
